// File: rtl/cpu_pkg.sv
// Shared state encoding and instruction field layout for the fetch unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ISSUE   = 2'd3
  } state_e;

  localparam int INSTR_W = 16;

  // Instruction field positions
  localparam int A_BIT   = 15;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 13;
  localparam int COMP_HI = 12;
  localparam int COMP_LO = 6;
  localparam int DEST_HI = 5;
  localparam int DEST_LO = 3;
  localparam int JMP_HI  = 2;
  localparam int JMP_LO  = 0;
  localparam int JMP_W   = JMP_HI - JMP_LO + 1;

  localparam logic       A_OPCODE = 1'b0;
  localparam logic [2:0] C_OPCODE = 3'b111;

  function automatic logic is_c_instr(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO] == C_OPCODE;
  endfunction

  function automatic logic is_a_instr(input logic [INSTR_W-1:0] instr);
    return instr[A_BIT] == A_OPCODE;
  endfunction

endpackage

// File: rtl/cpu_jump_cond.sv
// Combinational jump decision from the jump bits and the ALU flags.
module cpu_jump_cond
  import cpu_pkg::*;
(
  input  logic [JMP_W-1:0] j,
  input  logic             zr,
  input  logic             ng,
  input  logic             is_c,
  output logic             taken
);

  // j[2]: result < 0, j[1]: result == 0, j[0]: result > 0
  assign taken = is_c & ((j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr));

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch sequencer: reads the ROM, presents one instruction at a
// time with valid/ready, and picks the next PC from the jump condition.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | post-reset settle cycle, no ROM access
//   ST_FETCH   | ROM read strobed at PC unless halted
//   ST_CAPTURE | ROM word latched into the instruction register
//   ST_ISSUE   | instruction valid, waiting for the consumer to accept it
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic [PC_WIDTH-1:0] o_rom_addr,
  output logic                o_rom_en,
  input  logic [15:0]         i_rom_data,
  output logic [15:0]         o_instr,
  output logic                o_instr_valid,
  input  logic                i_instr_ready,
  output logic [PC_WIDTH-1:0] o_pc,
  input  logic                i_alu_zr,
  input  logic                i_alu_ng,
  input  logic [15:0]         i_a_reg,
  input  logic                i_halt,
  output logic                o_jump_taken
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] instr_pc_q;
  logic [15:0]         instr_q;
  logic                valid_q;
  logic                jump_q;
  logic                fire;
  logic                is_c;
  logic                taken;

  assign fire = valid_q & i_instr_ready;
  assign is_c = is_c_instr(instr_q);

  cpu_jump_cond u_jump_cond (
    .j     (instr_q[JMP_HI:JMP_LO]),
    .zr    (i_alu_zr),
    .ng    (i_alu_ng),
    .is_c  (is_c),
    .taken (taken)
  );

  // Flags and A are only meaningful in the fire cycle; pc_d is only used then.
  always_comb begin
    pc_d = pc_q + PC_ONE;
    if (taken) begin
      pc_d = i_a_reg[PC_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      instr_pc_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      jump_q     <= 1'b0;
    end else begin
      jump_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (!i_halt) begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          instr_q    <= i_rom_data;
          instr_pc_q <= pc_q;
          valid_q    <= 1'b1;
          state_q    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (fire) begin
            pc_q    <= pc_d;
            jump_q  <= taken;
            valid_q <= 1'b0;
            state_q <= ST_FETCH;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rom_addr    = pc_q;
  assign o_rom_en      = (state_q == ST_FETCH) & ~i_halt;
  assign o_instr       = instr_q;
  assign o_instr_valid = valid_q;
  assign o_pc          = instr_pc_q;
  assign o_jump_taken  = jump_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Scoreboard bench for cpu_fetch_unit: directed scenarios followed by random
// ready/halt/flag traffic against a behavioural fetch model.
module tb_cpu_fetch_unit;

  localparam int PCW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [PCW-1:0] rom_addr;
  logic           rom_en;
  logic [15:0]    rom_data;
  logic [15:0]    instr;
  logic           valid;
  logic           ready;
  logic [PCW-1:0] pc;
  logic           zr;
  logic           ng;
  logic [15:0]    a_reg;
  logic           halt;
  logic           jump;

  always #5 clk = ~clk;

  cpu_fetch_unit #(.PC_WIDTH(PCW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_rom_addr    (rom_addr),
    .o_rom_en      (rom_en),
    .i_rom_data    (rom_data),
    .o_instr       (instr),
    .o_instr_valid (valid),
    .i_instr_ready (ready),
    .o_pc          (pc),
    .i_alu_zr      (zr),
    .i_alu_ng      (ng),
    .i_a_reg       (a_reg),
    .i_halt        (halt),
    .o_jump_taken  (jump)
  );

  logic [15:0] rom [0:65535];

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom[rom_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Jump rule stated as "does the jump field select the result's sign class".
  function automatic bit model_taken(input logic [15:0] ins, input bit f_zr, input bit f_ng);
    if (ins[15:13] != 3'b111) return 1'b0;
    if (f_ng) return ins[2];
    if (f_zr) return ins[1];
    return ins[0];
  endfunction

  typedef struct {
    logic [15:0]    instr;
    logic [PCW-1:0] pc;
  } exp_t;

  exp_t           q[$];
  exp_t           cur;
  bit             have_cur;
  logic [PCW-1:0] exp_pc;
  bit             exp_jump;
  bit             prev_hold;
  bit             fired_last;
  bit             tk;
  int             cyc = 0;
  int             en_cyc = 0;
  int             stall_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("reset_ctrl", {29'd0, rom_en, valid, jump}, 32'd0);
      chk("reset_addr_pc", {rom_addr, pc}, 32'd0);
      chk("reset_instr", {16'd0, instr}, 32'd0);
      q.delete();
      exp_pc     = '0;
      exp_jump   = 1'b0;
      prev_hold  = 1'b0;
      fired_last = 1'b0;
      have_cur   = 1'b0;
      stall_cnt  = 0;
    end else begin
      chk("jump_pulse", {31'd0, jump}, {31'd0, exp_jump});
      exp_jump = 1'b0;
      if (fired_last) begin
        chk("valid_cleared_after_fire", {31'd0, valid}, 32'd0);
        if (!halt) chk("fetch_after_fire", {31'd0, rom_en}, 32'd1);
      end
      fired_last = 1'b0;
      if (halt) chk("rom_en_while_halt", {31'd0, rom_en}, 32'd0);
      if (valid) chk("rom_en_during_issue", {31'd0, rom_en}, 32'd0);
      if (rom_en) begin
        chk("rom_addr", {16'd0, rom_addr}, {16'd0, exp_pc});
        q.push_back('{rom[exp_pc], exp_pc});
        en_cyc = cyc;
      end
      if (valid) begin
        if (!prev_hold) begin
          if (q.size() == 0) begin
            chk("unexpected_valid", {31'd0, valid}, 32'd0);
            have_cur = 1'b0;
          end else begin
            cur      = q.pop_front();
            have_cur = 1'b1;
            chk("instr", {16'd0, instr}, {16'd0, cur.instr});
            chk("instr_pc", {16'd0, pc}, {16'd0, cur.pc});
            chk("fetch_latency", cyc - en_cyc, 32'd2);
          end
        end else if (have_cur) begin
          chk("instr_stable", {16'd0, instr}, {16'd0, cur.instr});
          chk("pc_stable", {16'd0, pc}, {16'd0, cur.pc});
        end
        if (ready && have_cur) begin
          tk         = model_taken(cur.instr, zr, ng);
          exp_pc     = tk ? a_reg[PCW-1:0] : cur.pc + 16'd1;
          exp_jump   = tk;
          fired_last = 1'b1;
          have_cur   = 1'b0;
        end
        prev_hold = !ready;
      end else begin
        prev_hold = 1'b0;
      end
      if (!halt && !rom_en && !valid) stall_cnt++;
      else stall_cnt = 0;
      if (stall_cnt > 3) begin
        chk("forward_progress", stall_cnt, 32'd3);
        stall_cnt = 0;
      end
    end
  end

  task automatic wait_valid();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid) return;
    end
    chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_fetch(input logic [PCW-1:0] addr);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rom_en) begin
        chk("directed_fetch_addr", {16'd0, rom_addr}, {16'd0, addr});
        return;
      end
    end
    chk("wait_fetch_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    ready = 1'b1;
    halt  = 1'b0;
    zr    = 1'b0;
    ng    = 1'b0;
    a_reg = 16'h0000;
    for (int i = 0; i < 65536; i++) rom[i] = 16'($urandom);
    rom[16'h0000] = 16'h0005;
    rom[16'h0001] = 16'hE307;
    rom[16'h0040] = 16'hE302;
    rom[16'h0041] = 16'hE302;
    rom[16'h0100] = 16'hE307;
    rom[16'hFFFF] = 16'h1234;
    rom[16'h0200] = 16'hC007;
    rom[16'h0201] = 16'hE000;
    rom[16'h0202] = 16'h0777;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // First fetch timing from reset release
    @(negedge clk) chk("c0_rom_en", {31'd0, rom_en}, 32'd0);
    @(negedge clk) begin
      chk("c1_rom_en", {31'd0, rom_en}, 32'd1);
      chk("c1_addr", {16'd0, rom_addr}, 32'd0);
    end
    @(negedge clk) chk("c2_valid", {31'd0, valid}, 32'd0);
    @(negedge clk) begin
      chk("c3_valid", {31'd0, valid}, 32'd1);
      chk("c3_instr", {16'd0, instr}, 32'h0005);
      chk("c3_pc", {16'd0, pc}, 32'd0);
    end
    wait_fetch(16'h0001);

    // Unconditional jump
    wait_valid();
    a_reg = 16'h0040;
    wait_fetch(16'h0040);
    chk("jmp_pulse_directed", {31'd0, jump}, 32'd1);

    // JEQ not taken, then taken
    wait_valid();
    zr = 1'b0;
    wait_fetch(16'h0041);
    wait_valid();
    zr    = 1'b1;
    a_reg = 16'h0100;
    wait_fetch(16'h0100);

    // Consumer stall
    @(posedge clk); #1;
    ready = 1'b0;
    zr    = 1'b0;
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      chk("stall_instr", {16'd0, instr}, 32'h0000E307);
      chk("stall_pc", {16'd0, pc}, 32'h00000100);
      chk("stall_no_fetch", {31'd0, rom_en}, 32'd0);
    end
    @(posedge clk); #1;
    a_reg = 16'hFFFF;
    ready = 1'b1;
    wait_fetch(16'hFFFF);

    // Wrap from all-ones
    wait_valid();
    zr = 1'b1;
    wait_fetch(16'h0000);
    wait_valid();
    zr = 1'b0;
    wait_fetch(16'h0001);
    wait_valid();
    a_reg = 16'h0200;
    wait_fetch(16'h0200);

    // Unknown opcode and j=000 never jump
    wait_valid();
    ng    = 1'b1;
    a_reg = 16'h0999;
    wait_fetch(16'h0201);
    wait_valid();
    ng = 1'b0;
    zr = 1'b1;
    wait_fetch(16'h0202);

    // Halt raised in ISSUE, then reset during CAPTURE
    wait_valid();
    halt = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk) chk("halt_no_fetch", {31'd0, rom_en}, 32'd0);
    @(posedge clk); #1;
    halt = 1'b0;
    wait_fetch(16'h0203);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_fetch(16'h0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst   = (i == 1500);
      ready = ($urandom_range(0, 9) < 7);
      halt  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       begin zr = 1'b0; ng = 1'b0; end
        1:       begin zr = 1'b1; ng = 1'b0; end
        default: begin zr = 1'b0; ng = 1'b1; end
      endcase
      a_reg = 16'($urandom);
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_unit.md
CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

Interface
REQ-001 SHALL have parameter: PC_WIDTH, 16, width of the program counter and ROM address.
REQ-002 SHALL have port: i_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: i_rst  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have port: o_rom_addr  out  PC_WIDTH  instruction ROM read address, driven from the PC register.
REQ-005 SHALL have port: o_rom_en  out  1  ROM read strobe; data is valid on i_rom_data exactly one cycle later.
REQ-006 SHALL have port: i_rom_data  in  16  ROM read data.
REQ-007 SHALL have port: o_instr  out  16  registered instruction presented to the control unit.
REQ-008 SHALL have port: o_instr_valid  out  1  o_instr is valid.
REQ-009 SHALL have port: i_instr_ready  in  1  downstream accepts o_instr; fire = o_instr_valid & i_instr_ready.
REQ-010 SHALL have port: o_pc  out  PC_WIDTH  address that o_instr was fetched from.
REQ-011 SHALL have port: i_alu_zr  in  1  ALU result equals zero, for the instruction on o_instr.
REQ-012 SHALL have port: i_alu_ng  in  1  ALU result is negative, for the instruction on o_instr.
REQ-013 SHALL have port: i_a_reg  in  16  current A-register value, used as the jump target.
REQ-014 SHALL have port: i_halt  in  1  suppresses new fetches while high.
REQ-015 SHALL have port: o_jump_taken  out  1  single-cycle pulse on a fire that takes a jump.

Function
REQ-016 SHALL implement four states: IDLE, FETCH, CAPTURE and ISSUE.
REQ-017 IDLE SHALL drive o_rom_en=0 and SHALL go to FETCH on the next cycle.
REQ-018 FETCH SHALL drive o_rom_en = ~i_halt.
REQ-019 FETCH SHALL go to CAPTURE only if i_halt=0; otherwise it SHALL remain in FETCH.
REQ-020 CAPTURE SHALL latch i_rom_data into o_instr and the current PC into o_pc, then go to ISSUE.
REQ-021 ISSUE SHALL hold o_instr_valid=1, with o_instr and o_pc stable, until fire.
REQ-022 On fire the block SHALL update the PC, clear o_instr_valid and go to FETCH.
REQ-023 Throughput SHALL be one instruction per 3 cycles when i_instr_ready is held high.
REQ-024 Fetch-to-valid latency SHALL be 2 cycles after the o_rom_en cycle.
REQ-025 A C-instruction SHALL be identified as o_instr[15:13]=3'b111; an A-instruction as o_instr[15]=0.
REQ-026 Jump bits SHALL be j=o_instr[2:0].
REQ-027 The jump SHALL be taken iff C-instruction & ((j[2]&ng) | (j[1]&zr) | (j[0]&~ng&~zr)).
REQ-028 An A-instruction, or any instruction with j=000, SHALL never jump.
REQ-029 Next PC on a taken fire SHALL be i_a_reg[PC_WIDTH-1:0], with upper bits truncated.
REQ-030 Next PC on a not-taken fire SHALL be PC+1, modulo 2^PC_WIDTH; PC=all-ones SHALL wrap to 0.
REQ-031 o_jump_taken SHALL be registered and high for exactly the cycle after a taken fire.
REQ-032 Flags and i_a_reg SHALL be sampled only in the fire cycle.
REQ-033 i_halt SHALL have no effect in ISSUE; it takes effect at the next FETCH.
REQ-034 A ready that arrives in the same cycle valid first rises SHALL fire in that cycle.
REQ-035 Instructions whose opcode is neither A nor C SHALL advance as not-taken.

Reset
REQ-036 While i_rst=1: state=IDLE, PC=0, o_pc=0, o_instr=0, o_instr_valid=0, o_jump_taken=0, o_rom_en=0.
REQ-037 Reset asserted mid-operation SHALL discard any in-flight fetch; after release, the first fetch SHALL be from address 0.

Structure
REQ-038 A shared package cpu_pkg SHALL hold the state enum, the instruction field positions (A bit, comp, dest, jmp) and the A/C opcode constants.
REQ-039 The jump condition SHALL be a combinational sub-module cpu_jump_cond (inputs: j, zr, ng, is_c; output: taken).

Verification
REQ-040 Reset release, ROM word[0]=16'h0005, ready=1 -> o_rom_en at cycle 1 with addr 0; valid at cycle 3; o_instr=0005; o_pc=0; next fetch at addr 1.
REQ-041 Instruction 16'hE307 (JMP) with i_a_reg=16'h0040 -> o_jump_taken pulse; next o_rom_addr=0x0040.
REQ-042 Instruction 16'hE302 (JEQ): zr=0 -> next addr PC+1; zr=1 -> next addr=i_a_reg.
REQ-043 Ready held low for 5 cycles -> o_instr and o_pc stable, no o_rom_en; a single fire follows once ready rises.
REQ-044 PC=16'hFFFF with a non-jump instruction -> next fetch from addr 0.
REQ-045 i_halt=1 during FETCH for 4 cycles, and i_rst pulsed during CAPTURE -> no o_rom_en while halted; after reset, fetch resumes from 0 with valid=0 meanwhile.
